// File: rtl/pow_pkg.sv
// Shared types and defaults for the proof-of-work nonce search controller.
package pow_pkg;

  localparam int unsigned DefHashBytes = 4;
  localparam int unsigned DefNonceW    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRecv,
    StDecide
  } pow_state_e;

  // Running result of the MSB-first bytewise hash-vs-target comparison.
  typedef enum logic [1:0] {
    CmpEq,
    CmpLt,
    CmpGt
  } cmp_state_e;

  // Byte-index counter width; a one-byte hash still needs a 1-bit counter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eightBit_comparator.sv
// 8-bit magnitude comparator: exactly one of g/e/l is high for any a, b.
module eightBit_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       g,
  output logic       e,
  output logic       l
);

  assign g = (a > b);
  assign e = (a == b);
  assign l = (a < b);

endmodule

// File: rtl/pow_nonce_search.sv
// Proof-of-work nonce search: issues nonces, compares returned hash bytes to a latched target.
// Build option POW_TARGET_LE_EN: a hash equal to the target also counts as success.
module pow_nonce_search
  import pow_pkg::*;
#(
  parameter int unsigned HASH_BYTES = DefHashBytes,
  parameter int unsigned NONCE_W    = DefNonceW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [HASH_BYTES*8-1:0] target,
  input  logic [NONCE_W-1:0]      nonce_base,
  input  logic [NONCE_W-1:0]      nonce_limit,
  output logic                    hreq_valid,
  input  logic                    hreq_ready,
  output logic [NONCE_W-1:0]      hreq_nonce,
  input  logic                    hb_valid,
  input  logic [7:0]              hb_data,
  output logic                    hb_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic                    exhausted,
  output logic [NONCE_W-1:0]      result_nonce
);

  localparam int unsigned IdxW = idx_width(HASH_BYTES);
  localparam int unsigned TgtW = HASH_BYTES * 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(HASH_BYTES - 1);

  pow_state_e        state_q;
  cmp_state_e        cmp_q;
  cmp_state_e        cmp_next;
  logic [TgtW-1:0]   target_q;
  logic [NONCE_W-1:0] limit_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [IdxW-1:0]   byte_idx_q;
  logic [7:0]        tgt_byte;
  logic              cmp_gt;
  logic              cmp_eq;
  logic              cmp_lt;
  logic              pass;

  assign hreq_nonce = nonce_q;

  // Target byte aligned with the incoming hash byte (MSB byte arrives first).
  always_comb begin
    tgt_byte = '0;
    for (int unsigned i = 0; i < HASH_BYTES; i++) begin
      if (byte_idx_q == IdxW'(i)) begin
        tgt_byte = target_q[(HASH_BYTES-1-i)*8 +: 8];
      end
    end
  end

  eightBit_comparator u_cmp (
    .a (hb_data),
    .b (tgt_byte),
    .g (cmp_gt),
    .e (cmp_eq),
    .l (cmp_lt)
  );

  // Only the first differing byte decides; once LT/GT the result is frozen.
  always_comb begin
    cmp_next = cmp_q;
    if (cmp_q == CmpEq) begin
      case ({cmp_gt, cmp_eq, cmp_lt})
        3'b100:  cmp_next = CmpGt;
        3'b001:  cmp_next = CmpLt;
        default: cmp_next = cmp_q;
      endcase
    end
  end

`ifdef POW_TARGET_LE_EN
  assign pass = (cmp_q != CmpGt);
`else
  assign pass = (cmp_q == CmpLt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cmp_q        <= CmpEq;
      target_q     <= '0;
      limit_q      <= '0;
      nonce_q      <= '0;
      byte_idx_q   <= '0;
      hreq_valid   <= 1'b0;
      hb_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      result_nonce <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            target_q   <= target;
            limit_q    <= nonce_limit;
            nonce_q    <= nonce_base;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            busy       <= 1'b1;
            hreq_valid <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (hreq_valid && hreq_ready) begin
            hreq_valid <= 1'b0;
            hb_ready   <= 1'b1;
            byte_idx_q <= '0;
            cmp_q      <= CmpEq;
            state_q    <= StRecv;
          end
        end
        StRecv: begin
          if (hb_valid && hb_ready) begin
            cmp_q <= cmp_next;
            if (byte_idx_q == LastIdx) begin
              hb_ready <= 1'b0;
              state_q  <= StDecide;
            end else begin
              byte_idx_q <= byte_idx_q + IdxW'(1);
            end
          end
        end
        StDecide: begin
          if (pass) begin
            found        <= 1'b1;
            result_nonce <= nonce_q;
            done         <= 1'b1;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end else if (nonce_q == limit_q) begin
            exhausted <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else begin
            // Wraps modulo 2^NONCE_W, so limit below base sweeps through zero.
            nonce_q    <= nonce_q + NONCE_W'(1);
            hreq_valid <= 1'b1;
            state_q    <= StIssue;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_nonce_search.sv
// Self-checking bench for pow_nonce_search: hash-core responder plus a nonce-sweep reference model.
module tb_pow_nonce_search;

  localparam int unsigned HB = 4;
  localparam int unsigned NW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   target = '0;
  logic [NW-1:0] nonce_base = '0;
  logic [NW-1:0] nonce_limit = '0;
  logic          hreq_valid;
  logic          hreq_ready = 1'b0;
  logic [NW-1:0] hreq_nonce;
  logic          hb_valid = 1'b0;
  logic [7:0]    hb_data = '0;
  logic          hb_ready;
  logic          busy;
  logic          done;
  logic          found;
  logic          exhausted;
  logic [NW-1:0] result_nonce;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pow_nonce_search #(
    .HASH_BYTES (HB),
    .NONCE_W    (NW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .target       (target),
    .nonce_base   (nonce_base),
    .nonce_limit  (nonce_limit),
    .hreq_valid   (hreq_valid),
    .hreq_ready   (hreq_ready),
    .hreq_nonce   (hreq_nonce),
    .hb_valid     (hb_valid),
    .hb_data      (hb_data),
    .hb_ready     (hb_ready),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .exhausted    (exhausted),
    .result_nonce (result_nonce)
  );

  // Hash core behaviour knobs and observations.
  int            ready_delay = 0;
  int            gap_fixed = 0;
  int            gap_rand = 0;
  bit            noise = 1'b0;
  logic [31:0]   hash_tab [int unsigned];
  logic [31:0]   hash_default = '0;
  logic [NW-1:0] req_q [$];
  int            next_gap_q [$];
  int            bytes_consumed = 0;
  int            done_cnt = 0;
  bit            overlap_seen = 1'b0;
  bit            unstable_seen = 1'b0;

  function automatic logic [31:0] hash_of(input logic [NW-1:0] n);
    if (hash_tab.exists(32'(n))) return hash_tab[32'(n)];
    return hash_default;
  endfunction

  function automatic bit passes(input logic [31:0] h, input logic [31:0] t);
`ifdef POW_TARGET_LE_EN
    return h <= t;
`else
    return h < t;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: accepts requests after ready_delay, streams hash bytes MSB first with gaps.
  int          phase = 0;
  int          wait_cnt = 0;
  int          bidx = 0;
  int          gapc = 0;
  int          gap_cur = 0;
  int          post_cnt = 0;
  logic [31:0] hash_cur = '0;
  bit          prev_stall = 1'b0;
  logic [NW-1:0] prev_nonce = '0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (hreq_valid && hb_ready) overlap_seen = 1'b1;
    if (rst_n && prev_stall && !(hreq_valid && hreq_nonce == prev_nonce)) unstable_seen = 1'b1;
    if (!rst_n) begin
      phase      = 0;
      wait_cnt   = 0;
      hreq_ready = 1'b0;
      hb_valid   = 1'b0;
    end else begin
      case (phase)
        0: begin
          hb_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          hb_data  = 8'($urandom);
          if (hreq_valid) begin
            if (wait_cnt < ready_delay) begin
              wait_cnt++;
              hreq_ready = 1'b0;
            end else begin
              hreq_ready = 1'b1;
              req_q.push_back(hreq_nonce);
              hash_cur = hash_of(hreq_nonce);
              bidx     = 0;
              gapc     = 0;
              gap_cur  = gap_fixed + int'($urandom_range(0, gap_rand));
              phase    = 1;
            end
          end else begin
            hreq_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          end
        end
        1: begin
          hreq_ready = 1'b0;
          wait_cnt   = 0;
          if (gapc < gap_cur) begin
            hb_valid = 1'b0;
            gapc++;
          end else begin
            hb_valid = 1'b1;
            hb_data  = hash_cur[(HB-1-bidx)*8 +: 8];
            if (hb_ready) begin
              bytes_consumed++;
              bidx++;
              gapc    = 0;
              gap_cur = gap_fixed + int'($urandom_range(0, gap_rand));
              if (bidx == HB) begin
                phase    = 2;
                post_cnt = 0;
              end
            end
          end
        end
        default: begin
          hb_valid = 1'b0;
          post_cnt++;
          if (hreq_valid || done) begin
            next_gap_q.push_back(post_cnt);
            phase = 0;
          end else if (post_cnt > 8) begin
            phase = 0;
          end
        end
      endcase
    end
    prev_stall = hreq_valid && !hreq_ready;
    prev_nonce = hreq_nonce;
  end

  task automatic run_search(input string tag, input logic [31:0] tgt, input logic [NW-1:0] base,
                            input logic [NW-1:0] limit, input bit mid_start);
    bit            m_found;
    logic [NW-1:0] m_res;
    logic [NW-1:0] m_q [$];
    logic [NW-1:0] n;
    int            bad;
    int            nmin;
    // Reference: walk the range in order, stop at the first passing hash or at the limit.
    m_q = {};
    m_found = 1'b0;
    m_res = '0;
    n = base;
    for (int k = 0; k < 70000; k++) begin
      m_q.push_back(n);
      if (passes(hash_of(n), tgt)) begin
        m_found = 1'b1;
        m_res = n;
        break;
      end
      if (n == limit) break;
      n = n + 16'd1;
    end
    req_q = {};
    next_gap_q = {};
    done_cnt = 0;
    @(negedge clk); #1;
    target = tgt;
    nonce_base = base;
    nonce_limit = limit;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    target = 32'hFFFF_FFFF;
    nonce_base = 16'($urandom);
    nonce_limit = 16'($urandom);
    if (mid_start) begin
      repeat (4) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
    end
    for (int c = 0; c < 5000 && done_cnt == 0; c++) begin
      @(negedge clk); #1;
    end
    check({tag, " done seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " found"}, 32'(found), 32'(m_found));
    check({tag, " exhausted"}, 32'(exhausted), 32'(!m_found));
    check({tag, " busy after"}, 32'(busy), 32'd0);
    if (m_found) check({tag, " result"}, 32'(result_nonce), 32'(m_res));
    check({tag, " requests"}, 32'(req_q.size()), 32'(m_q.size()));
    bad = 0;
    nmin = (req_q.size() < m_q.size()) ? req_q.size() : m_q.size();
    for (int i = 0; i < nmin; i++) if (req_q[i] !== m_q[i]) bad++;
    check({tag, " order"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [31:0]   tgt;
    logic [NW-1:0] base;
    logic [NW-1:0] limit;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset found", 32'(found), 32'd0);
    check("reset exhausted", 32'(exhausted), 32'd0);
    check("reset hreq_valid", 32'(hreq_valid), 32'd0);
    check("reset hb_ready", 32'(hb_ready), 32'd0);
    check("reset result", 32'(result_nonce), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Find at nonce 3.
    hash_default = 32'h0100_0000;
    hash_tab[3] = 32'h00FE_1234;
    run_search("find3", 32'h00FF_0000, 16'd0, 16'd5, 1'b0);
    check("find3 result const", 32'(result_nonce), 32'd3);

    // Equal hash is not strictly below the target.
    hash_tab.delete();
    hash_default = 32'h00FF_0000;
    run_search("equal", 32'h00FF_0000, 16'd10, 16'd12, 1'b0);

    // Early GT decision with 2-cycle gaps between bytes.
    hash_default = 32'h01AB_CDEF;
    gap_fixed = 2;
    b0 = bytes_consumed;
    run_search("early", 32'h00FF_0000, 16'd7, 16'd8, 1'b0);
    check("early bytes consumed", 32'(bytes_consumed - b0), 32'd8);
    check("early reissue after decide", 32'(next_gap_q.size() > 0 ? next_gap_q[0] : 0), 32'd2);
    gap_fixed = 0;

    // Range wrapping through zero.
    run_search("wrap", 32'h00FF_0000, 16'hFFFE, 16'h0001, 1'b0);

    // Backpressure on requests, with an ignored start mid-search.
    ready_delay = 10;
    unstable_seen = 1'b0;
    run_search("backpressure", 32'h00FF_0000, 16'd100, 16'd101, 1'b1);
    check("backpressure nonce stable", 32'(unstable_seen), 32'd0);
    ready_delay = 0;

    // Randomized searches with noise, gaps and request delays.
    noise = 1'b1;
    gap_rand = 2;
    for (int r = 0; r < 6; r++) begin
      ready_delay = int'($urandom_range(0, 3));
      tgt = $urandom;
      base = 16'($urandom);
      limit = base + 16'($urandom_range(0, 6));
      hash_tab.delete();
      hash_default = 32'hFFFF_FFFF;
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 3))
          0:       hash_tab[32'(16'(base + 16'(k)))] = tgt;
          1:       hash_tab[32'(16'(base + 16'(k)))] = $urandom;
          default: hash_tab[32'(16'(base + 16'(k)))] = tgt | 32'h8000_0000 | $urandom;
        endcase
      end
      run_search($sformatf("random%0d", r), tgt, base, limit, 1'b0);
    end
    noise = 1'b0;
    gap_rand = 0;
    ready_delay = 0;

    // Leave a nonzero result behind, then reset in the middle of a hash stream.
    hash_tab.delete();
    hash_default = 32'h0100_0000;
    hash_tab[32'h55] = 32'h0000_0000;
    run_search("find55", 32'h00FF_0000, 16'h0050, 16'h0060, 1'b0);
    hash_tab.delete();
    b0 = bytes_consumed;
    @(negedge clk); #1;
    target = 32'h00FF_0000;
    nonce_base = 16'd20;
    nonce_limit = 16'd30;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && (bytes_consumed - b0) < 2; c++) begin
      @(negedge clk); #1;
    end
    check("midrecv bytes reached", 32'(bytes_consumed - b0), 32'd2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrecv busy", 32'(busy), 32'd0);
    check("midrecv hreq_valid", 32'(hreq_valid), 32'd0);
    check("midrecv hb_ready", 32'(hb_ready), 32'd0);
    check("midrecv found", 32'(found), 32'd0);
    check("midrecv exhausted", 32'(exhausted), 32'd0);
    check("midrecv result", 32'(result_nonce), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    hash_tab[41] = 32'h0000_1111;
    run_search("postreset", 32'h00FF_0000, 16'd40, 16'd42, 1'b0);

    check("no hreq_valid/hb_ready overlap", 32'(overlap_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pow_nonce_search.md
Name: pow_nonce_search

Overview:
- Proof-of-work search controller that sits directly downstream of the team's 8-bit magnitude comparator (`eightBit_comparator`, outputs g/e/l) and reuses it.
- Issues candidate nonces to an external hash core and receives each hash as a byte stream, MSB byte first.
- Compares each hash bytewise against a latched difficulty target and stops at the first nonce whose hash is strictly below the target, or when the nonce range is exhausted.

Parameters:
- HASH_BYTES, 4, hash and target width in bytes (minimum 1).
- NONCE_W, 16, nonce width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a search; sampled only in IDLE.
- target  in  HASH_BYTES*8  difficulty target; latched on an accepted start.
- nonce_base  in  NONCE_W  first nonce; latched on start.
- nonce_limit  in  NONCE_W  last nonce; latched on start.
- hreq_valid  out  1  nonce request valid.
- hreq_ready  in  1  hash core accepts the request.
- hreq_nonce  out  NONCE_W  nonce being requested.
- hb_valid  in  1  hash byte valid.
- hb_data  in  8  hash byte, MSB byte first.
- hb_ready  out  1  controller accepts a byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at search end.
- found  out  1  sticky: a qualifying nonce was found.
- exhausted  out  1  sticky: range ended without success.
- result_nonce  out  NONCE_W  the qualifying nonce; valid when found=1.

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, FSM goes to IDLE, and all internal registers clear.
- FSM states: IDLE, ISSUE, RECV, DECIDE.
- IDLE
  - start=1: latch target, base and limit; set nonce_reg=base; clear found and exhausted; go to ISSUE.
  - start while busy=1 is ignored.
- ISSUE
  - hreq_valid=1; hreq_nonce=nonce_reg, held stable until the handshake.
  - On hreq_valid&hreq_ready: byte_idx=0, cmp_state=EQ, go to RECV.
- RECV
  - hb_ready=1. A byte is consumed on hb_valid&hb_ready.
  - Consumed byte i is compared against target[(HASH_BYTES-1-i)*8 +: 8] by the comparator.
  - cmp_state=EQ: update to LT if hash byte < target byte, GT if >, stay EQ if equal.
  - cmp_state already LT or GT: frozen (early decision), but the remaining bytes are still consumed and discarded.
  - After byte HASH_BYTES-1 is consumed: go to DECIDE.
- DECIDE (exactly one cycle)
  - cmp_state==LT: found=1, result_nonce=nonce_reg, done=1, go to IDLE.
  - Else if nonce_reg==nonce_limit: exhausted=1, done=1, go to IDLE.
  - Else: nonce_reg=nonce_reg+1, modulo 2^NONCE_W, go to ISSUE.
- Success rule: equal (EQ at the end) is a failure; only strictly-less passes.
- Range and wrap
  - nonce_limit < nonce_base wraps through 0.
  - base==limit tries exactly one nonce.
  - base==limit+1 (mod 2^NONCE_W) covers the full space.
- Latency per nonce: at least 1 (ISSUE) + HASH_BYTES (RECV) + 1 (DECIDE) cycles, stretched by backpressure and hb_valid gaps.
- Persistence: found, exhausted and result_nonce hold until the next accepted start.
- Signal gating: hreq_valid and hb_ready are never high at the same time; hb_valid outside RECV is ignored.

Optional Feature:
- Macro: POW_TARGET_LE_EN.
- Defined: EQ at the end of the hash counts as success, i.e. hash <= target.
- Undefined: strictly hash < target.
- No port changes either way.

Decomposition:
- Shared package (pow_pkg):
  - FSM state encoding.
  - cmp_state encoding EQ/LT/GT.
  - Default HASH_BYTES and NONCE_W.
- One sub-module: instantiate the existing `eightBit_comparator` on (hb_data, selected target byte). Its g/e/l outputs drive the cmp_state update; no new comparator is written.

Test Plan:
- Find at nonce 3: HASH_BYTES=4, target=0x00FF0000, base=0, limit=5; the hash model returns 0x01000000 for nonces 0-2 and 0x00FE1234 for nonce 3. Required: 4 requests; found=1, result_nonce=3; one done pulse; exhausted=0.
- Equal hash: hash=0x00FF0000 for every nonce, base=10, limit=12. Required: nonces 10, 11 and 12 requested; exhausted=1, found=0. With POW_TARGET_LE_EN: found=1, result_nonce=10, 1 request.
- Early decision with gaps: first byte 0x01 (GT), then 3 bytes with 2-cycle hb_valid gaps. Required: all 4 bytes consumed; the next hreq_valid rises only after the DECIDE cycle.
- Wrap: base=0xFFFE, limit=0x0001, all hashes fail. Required: FFFE, FFFF, 0000, 0001 requested in order, then exhausted=1.
- Backpressure: hreq_ready held low for 10 cycles. Required: hreq_valid=1 and hreq_nonce stable throughout; a start pulse during the search is ignored.
- Reset mid-RECV: assert rst_n=0 after the 2nd byte. Required: immediately busy=0, hreq_valid=0, hb_ready=0, found=0, exhausted=0; after release, a new start runs cleanly from base.
